spkr_drv_mc: RTL and testbench

//  Parametrised multi-channel PDM speaker driver. Accepts audio frames (one sample per

---
 rtl/spkr_pkg.sv | 21 ++
 rtl/pdm_mod.sv | 32 +++
 rtl/spkr_drv_mc.sv | 137 +++++++++++++
 tb/tb_spkr_drv_mc.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spkr_pkg.sv
// Shared helpers for the multi-channel PDM speaker driver.
// Helpers work on a fixed 32-bit container, so a sample is at most 32 bits wide.
package spkr_pkg;

    localparam int unsigned MaxDw = 32;

    // Midscale code for a dw-bit duty word: 1 << (dw-1).
    function automatic logic [MaxDw-1:0] mid(input int unsigned dw);
        logic [MaxDw-1:0] one;
        one = {{(MaxDw-1){1'b0}}, 1'b1};
        return one << (dw - 1);
    endfunction

    // Two's complement flips to offset binary by inverting the MSB.
    function automatic logic [MaxDw-1:0] to_offset(input logic [MaxDw-1:0] sample,
                                                   input logic             signed_mode,
                                                   input int unsigned      dw);
        return signed_mode ? (sample ^ mid(dw)) : sample;
    endfunction

endpackage

// File: rtl/pdm_mod.sv
// First-order sigma-delta modulator: the accumulator carry is the PDM bit.
// A duty of d produces d ones in every 2^DW cycles.
module pdm_mod #(
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] duty_i,
    output logic          pdm_o
);

    logic [DW-1:0] acc_q, acc_d;
    logic          pdm_q, pdm_d;

    // Accumulator overflow wraps on purpose; the carry out is the output bit.
    always_comb begin
        {pdm_d, acc_d} = {1'b0, acc_q} + {1'b0, duty_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            pdm_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            pdm_q <= pdm_d;
        end
    end

    assign pdm_o = pdm_q;

endmodule

// File: rtl/spkr_drv_mc.sv
// Multi-channel PDM speaker driver: frame FIFO, sample-tick pop, per-channel duty
// registers and one sigma-delta modulator per channel.
module spkr_drv_mc
    import spkr_pkg::*;
#(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned DW         = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SAMPLE_DIV = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CH*DW-1:0]          in_data_i,
    input  logic                          in_vld_i,
    output logic                          in_rdy_o,
    input  logic                          signed_mode_i,
    input  logic                          mute_i,
    input  logic                          clr_flags_i,
    output logic                          underflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o,
    output logic [NUM_CH-1:0]             pdm_o
);

    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW   = PtrW + 1;
    localparam int unsigned TickW  = $clog2(SAMPLE_DIV);
    localparam int unsigned FrameW = NUM_CH * DW;

    localparam logic [DW-1:0]    Mid      = DW'(mid(DW));
    localparam logic [TickW-1:0] TickLast = TickW'(SAMPLE_DIV - 1);
    localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

    logic [FrameW-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
    logic [FrameW-1:0] duty_q, duty_d;
    logic              underflow_q, underflow_d;

    logic full, empty, tick, push, pop;

    assign full  = (cnt_q == CntFull);
    assign empty = (cnt_q == '0);
    assign tick  = (tick_cnt_q == TickLast);
    // Ready comes from the registered count only, so a same-cycle pop never frees a slot.
    assign push  = in_vld_i & ~full;
    assign pop   = tick & ~empty;

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // On an empty tick the duty registers simply hold, repeating the last sample.
    always_comb begin
        duty_d = duty_q;
        if (pop) begin
            for (int k = 0; k < NUM_CH; k++) begin
                duty_d[k*DW +: DW] = DW'(to_offset(MaxDw'(mem_q[rd_ptr_q][k*DW +: DW]),
                                                   signed_mode_i, DW));
            end
        end
    end

    // A new underflow outranks a clear landing in the same cycle.
    always_comb begin
        underflow_d = underflow_q;
        if (clr_flags_i) begin
            underflow_d = 1'b0;
        end
        if (tick && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            tick_cnt_q  <= '0;
            duty_q      <= {NUM_CH{Mid}};
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            duty_q      <= duty_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DW-1:0] eff_duty;

        assign eff_duty = mute_i ? Mid : duty_q[k*DW +: DW];

        pdm_mod #(
            .DW (DW)
        ) u_pdm_mod (
            .clk    (clk),
            .rst_n  (rst_n),
            .duty_i (eff_duty),
            .pdm_o  (pdm_o[k])
        );
    end

    assign in_rdy_o    = ~full;
    assign underflow_o = underflow_q;
    assign fifo_cnt_o  = cnt_q;

endmodule

// File: tb/tb_spkr_drv_mc.sv
// Scoreboard bench for spkr_drv_mc: frames queued at push, compared at pop, with
// PDM densities counted over full 2^DW-cycle windows.
module tb_spkr_drv_mc;

    localparam int NUM_CH = 2;
    localparam int DW     = 12;
    localparam int DEPTH  = 4;
    localparam int DIV    = 64;
    localparam int FW     = NUM_CH * DW;
    localparam int WIN    = 1 << DW;

    localparam logic [FW-1:0] MIDF = {NUM_CH{12'h800}};

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [FW-1:0] in_data = '0;
    logic          in_vld = 1'b0;
    logic          in_rdy;
    logic          signed_mode = 1'b0;
    logic          mute = 1'b0;
    logic          clr_flags = 1'b0;
    logic          underflow;
    logic [2:0]    fifo_cnt;
    logic [1:0]    pdm;

    int            n_checks = 0;
    int            n_fail = 0;

    logic [FW-1:0] sb[$];
    int            m_cnt = 0;
    int            m_tick = 0;
    bit            m_under = 1'b0;
    logic [FW-1:0] m_duty = MIDF;
    int            m_edge = 0;
    bit            last_push = 1'b0;

    spkr_drv_mc #(
        .NUM_CH     (NUM_CH),
        .DW         (DW),
        .FIFO_DEPTH (DEPTH),
        .SAMPLE_DIV (DIV)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_data_i     (in_data),
        .in_vld_i      (in_vld),
        .in_rdy_o      (in_rdy),
        .signed_mode_i (signed_mode),
        .mute_i        (mute),
        .clr_flags_i   (clr_flags),
        .underflow_o   (underflow),
        .fifo_cnt_o    (fifo_cnt),
        .pdm_o         (pdm)
    );

    always #5 clk = ~clk;

    // One clock step: advance the reference model, then check outputs 1 time unit later.
    task automatic cyc();
        bit            push, tick, pop, und, sm, clr;
        logic [FW-1:0] raw;
        push = in_vld && (m_cnt != DEPTH);
        tick = (m_tick == DIV - 1);
        pop  = tick && (m_cnt != 0);
        und  = tick && (m_cnt == 0);
        sm   = signed_mode;
        clr  = clr_flags;
        raw  = in_data;
        @(posedge clk);
        if (push) sb.push_back(raw);
        if (pop) begin
            raw = sb.pop_front();
            m_duty = sm ? (raw ^ MIDF) : raw;
        end
        if (push && !pop) m_cnt++;
        else if (pop && !push) m_cnt--;
        if (und) m_under = 1'b1;
        else if (clr) m_under = 1'b0;
        m_tick = tick ? 0 : m_tick + 1;
        last_push = push;
        m_edge++;
        #1;
        n_checks++;
        if (fifo_cnt !== 3'(m_cnt)) begin
            n_fail++;
            $display("FAIL fifo_cnt edge %0d: got %0d want %0d", m_edge, fifo_cnt, m_cnt);
        end
        n_checks++;
        if (in_rdy !== (m_cnt != DEPTH)) begin
            n_fail++;
            $display("FAIL in_rdy edge %0d: got %b want %b", m_edge, in_rdy, m_cnt != DEPTH);
        end
        n_checks++;
        if (underflow !== m_under) begin
            n_fail++;
            $display("FAIL underflow edge %0d: got %b want %b", m_edge, underflow, m_under);
        end
        if (pop) begin
            n_checks++;
            if (dut.duty_q !== m_duty) begin
                n_fail++;
                $display("FAIL duty_at_pop edge %0d: got %h want %h", m_edge, dut.duty_q, m_duty);
            end
        end
    endtask

    task automatic window(input int n, output int ones0, output int ones1);
        ones0 = 0;
        ones1 = 0;
        for (int i = 0; i < n; i++) begin
            cyc();
            ones0 += int'(pdm[0]);
            ones1 += int'(pdm[1]);
        end
    endtask

    task automatic wait_phase(input int p);
        int guard = 0;
        while (m_tick != p && guard <= DIV) begin
            cyc();
            guard++;
        end
        if (m_tick != p) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_phase: got phase %0d want %0d", m_tick, p);
        end
    endtask

    task automatic wait_drained();
        int guard = 0;
        while (sb.size() != 0 && guard < (DEPTH + 1) * DIV) begin
            cyc();
            guard++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d queued want 0", sb.size());
        end
    endtask

    task automatic do_reset();
        in_vld    = 1'b0;
        clr_flags = 1'b0;
        mute      = 1'b0;
        rst_n     = 1'b0;
        #2;
        n_checks++;
        if (pdm !== 2'b00 || fifo_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_async: got pdm=%b cnt=%0d want pdm=00 cnt=0", pdm, fifo_cnt);
        end
        sb.delete();
        m_cnt   = 0;
        m_tick  = 0;
        m_under = 1'b0;
        m_duty  = MIDF;
        m_edge  = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int o0, o1;
        do_reset();
        n_checks++;
        if (in_rdy !== 1'b1 || fifo_cnt !== 3'd0 || underflow !== 1'b0 || pdm !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b cnt=%0d uf=%b pdm=%b want 1 0 0 00",
                     in_rdy, fifo_cnt, underflow, pdm);
        end
        window(3 * DIV, o0, o1);
        n_checks++;
        if (o0 != 3 * DIV / 2 || o1 != 3 * DIV / 2) begin
            n_fail++;
            $display("FAIL idle_density: got %0d/%0d want %0d", o0, o1, 3 * DIV / 2);
        end
        n_checks++;
        if (underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_underflow: got %b want 1", underflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [FW-1:0] fr [5];
        int            i = 0;
        int            guard = 0;
        int            accept5 = -1;
        fr[0] = 24'h123_456;
        fr[1] = 24'hABC_DEF;
        fr[2] = 24'h000_FFF;
        fr[3] = 24'h800_7FF;
        fr[4] = 24'h5A5_A5A;
        do_reset();
        while (i < 5 && guard < 4 * DIV) begin
            in_vld  = 1'b1;
            in_data = fr[i];
            cyc();
            guard++;
            if (last_push) begin
                if (i == 3) begin
                    n_checks++;
                    if (in_rdy !== 1'b0) begin
                        n_fail++;
                        $display("FAIL rdy_after_4th: got %b want 0", in_rdy);
                    end
                end
                if (i == 4) accept5 = m_edge;
                i++;
            end
        end
        in_vld = 1'b0;
        n_checks++;
        if (accept5 != DIV + 1) begin
            n_fail++;
            $display("FAIL fifth_accept_edge: got %0d want %0d", accept5, DIV + 1);
        end
        wait_drained();
    endtask

    task automatic test_signed();
        int o0, o1;
        signed_mode = 1'b1;
        in_data     = {12'h7FF, 12'h800};
        in_vld      = 1'b1;
        cyc();
        in_vld = 1'b0;
        wait_drained();
        repeat (4) cyc();
        window(WIN, o0, o1);
        n_checks++;
        if (o0 != 0) begin
            n_fail++;
            $display("FAIL signed_min_ones: got %0d want 0", o0);
        end
        n_checks++;
        if (o1 != WIN - 1) begin
            n_fail++;
            $display("FAIL signed_max_ones: got %0d want %0d", o1, WIN - 1);
        end
        signed_mode = 1'b0;
    endtask

    task automatic test_offset();
        int o0, o1;
        in_data = {12'hC00, 12'h400};
        in_vld  = 1'b1;
        cyc();
        in_vld = 1'b0;
        wait_drained();
        repeat (4) cyc();
        window(WIN, o0, o1);
        n_checks++;
        if (o0 != WIN / 4 || o1 != 3 * WIN / 4) begin
            n_fail++;
            $display("FAIL offset_density: got %0d/%0d want %0d/%0d", o0, o1, WIN / 4, 3 * WIN / 4);
        end
    endtask

    task automatic test_mute();
        int            o0, o1;
        int            guard = 0;
        logic [FW-1:0] last;
        logic [FW-1:0] v;
        mute = 1'b1;
        v    = 24'h111_222;
        last = v;
        while (m_cnt < DEPTH && guard < 50) begin
            in_vld  = 1'b1;
            in_data = v;
            cyc();
            guard++;
            if (last_push) begin
                last = v;
                v    = v + 24'h135_079;
            end
        end
        in_vld = 1'b0;
        n_checks++;
        if (fifo_cnt !== 3'(DEPTH)) begin
            n_fail++;
            $display("FAIL mute_fill: got %0d want %0d", fifo_cnt, DEPTH);
        end
        window(WIN, o0, o1);
        n_checks++;
        if (o0 != WIN / 2 || o1 != WIN / 2) begin
            n_fail++;
            $display("FAIL mute_density: got %0d/%0d want %0d", o0, o1, WIN / 2);
        end
        n_checks++;
        if (fifo_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL mute_drain: got %0d want 0", fifo_cnt);
        end
        mute = 1'b0;
        cyc();
        window(WIN, o0, o1);
        n_checks++;
        if (o0 != int'(last[11:0]) || o1 != int'(last[23:12])) begin
            n_fail++;
            $display("FAIL unmute_density: got %0d/%0d want %0d/%0d",
                     o0, o1, last[11:0], last[23:12]);
        end
    endtask

    task automatic test_flags_and_reset();
        wait_phase(5);
        clr_flags = 1'b1;
        cyc();
        clr_flags = 1'b0;
        n_checks++;
        if (underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_flags: got %b want 0", underflow);
        end
        wait_phase(DIV - 1);
        clr_flags = 1'b1;
        cyc();
        clr_flags = 1'b0;
        n_checks++;
        if (underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL set_beats_clear: got %b want 1", underflow);
        end
        in_data = 24'hFFF_FFF;
        in_vld  = 1'b1;
        repeat (2) cyc();
        in_vld = 1'b0;
        cyc();
        n_checks++;
        if (fifo_cnt !== 3'd2) begin
            n_fail++;
            $display("FAIL pre_reset_cnt: got %0d want 2", fifo_cnt);
        end
        do_reset();
        n_checks++;
        if (fifo_cnt !== 3'd0 || underflow !== 1'b0 || in_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset: got cnt=%0d uf=%b rdy=%b want 0 0 1",
                     fifo_cnt, underflow, in_rdy);
        end
        repeat (8) cyc();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_signed();
        test_offset();
        test_mute();
        test_flags_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
